// File: rtl/lbist_pkg.sv
// Shared types and defaults for the LBIST scan-out compaction path.
package lbist_pkg;

    localparam int          DEFAULT_N_CHAINS = 20;
    localparam logic [31:0] DEFAULT_POLY     = 32'h04C11DB7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_COMPARE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: Galois feedback with parallel data injection.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int                MISR_W = 32,
    parameter int                DIN_W  = DEFAULT_N_CHAINS,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0] SEED   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DIN_W-1:0]  data_i,
    output logic [MISR_W-1:0] misr_o
);

    logic [MISR_W-1:0] misr_d;
    logic [MISR_W-1:0] misr_q;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        misr_d = misr_q;
        if (load_i) begin
            misr_d = SEED;
        end else if (step_i) begin
            misr_d = (misr_q << 1) ^ (misr_q[MISR_W-1] ? POLY : '0) ^ MISR_W'(data_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign misr_o = misr_q;

endmodule

// File: rtl/lbist_misr_compactor.sv
// Compacts scan-out chains into a MISR per shift window, checks window length and
// pattern count, and reports a go/no-go verdict against a golden signature.
module lbist_misr_compactor
    import lbist_pkg::*;
#(
    parameter int                  N_CHAINS   = DEFAULT_N_CHAINS,
    parameter int                  CHAIN_LEN  = 64,
    parameter int                  N_PATTERNS = 1024,
    parameter int                  MISR_W     = 32,
    parameter logic [MISR_W-1:0]   POLY       = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0]   SEED       = '0,
    parameter logic [MISR_W-1:0]   GOLDEN_SIG = '0,
    parameter logic [N_CHAINS-1:0] CHAIN_MASK = N_CHAINS'(20'h00300),
    localparam int                 PAT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_normal_i,
    input  logic                test_en_i,
    input  logic [N_CHAINS-1:0] scan_out_i,
    output logic                done_o,
    output logic                go_nogo_o,
    output logic                err_o,
    output logic [MISR_W-1:0]   signature_o,
    output logic [PAT_W-1:0]    pat_cnt_o
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 2);

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   shift_cnt_d, shift_cnt_q;
    logic [PAT_W-1:0]   pat_cnt_d, pat_cnt_q;
    logic               done_d, done_q;
    logic               go_nogo_d, go_nogo_q;
    logic               err_d, err_q;
    logic               test_normal_prev_q;
    logic               misr_load;
    logic               misr_step;
    logic [MISR_W-1:0]  misr;

    // Capture cycles (test_en_i low) never reach the MISR.
    assign misr_step = ((state_q == ST_ARMED) || (state_q == ST_SHIFT)) && test_en_i;

    lbist_misr #(
        .MISR_W (MISR_W),
        .DIN_W  (N_CHAINS),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (misr_load),
        .step_i (misr_step),
        .data_i (scan_out_i & ~CHAIN_MASK),
        .misr_o (misr)
    );

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        done_d      = done_q;
        go_nogo_d   = go_nogo_q;
        err_d       = err_q;
        misr_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (test_normal_i && !test_normal_prev_q) begin
                    state_d     = ST_ARMED;
                    misr_load   = 1'b1;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                    done_d      = 1'b0;
                    go_nogo_d   = 1'b0;
                    err_d       = 1'b0;
                end
            end
            ST_ARMED: begin
                if (!test_normal_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    go_nogo_d = 1'b0;
                end else if (test_en_i) begin
                    state_d     = ST_SHIFT;
                    shift_cnt_d = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!test_normal_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    go_nogo_d = 1'b0;
                end else if (test_en_i) begin
                    if (shift_cnt_q == CNT_W'(CHAIN_LEN)) begin
                        err_d = 1'b1;
                    end
                    if (shift_cnt_q != CNT_W'(CHAIN_LEN + 1)) begin
                        shift_cnt_d = shift_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Window end: length check, then either the next window or the verdict.
                    if (shift_cnt_q != CNT_W'(CHAIN_LEN)) begin
                        err_d = 1'b1;
                    end
                    pat_cnt_d   = pat_cnt_q + PAT_W'(1);
                    shift_cnt_d = '0;
                    state_d     = (pat_cnt_q == PAT_W'(N_PATTERNS - 1)) ? ST_COMPARE : ST_ARMED;
                end
            end
            ST_COMPARE: begin
                if (!test_normal_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    go_nogo_d = 1'b0;
                end else begin
                    go_nogo_d = (misr == GOLDEN_SIG) && !err_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!test_normal_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= ST_IDLE;
            shift_cnt_q        <= '0;
            pat_cnt_q          <= '0;
            done_q             <= 1'b0;
            go_nogo_q          <= 1'b0;
            err_q              <= 1'b0;
            test_normal_prev_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            shift_cnt_q        <= shift_cnt_d;
            pat_cnt_q          <= pat_cnt_d;
            done_q             <= done_d;
            go_nogo_q          <= go_nogo_d;
            err_q              <= err_d;
            test_normal_prev_q <= test_normal_i;
        end
    end

    assign done_o      = done_q;
    assign go_nogo_o   = go_nogo_q;
    assign err_o       = err_q;
    assign signature_o = misr;
    assign pat_cnt_o   = pat_cnt_q;

endmodule
